// File: rtl/sync_edge_event.sv
// sync_edge_event
//   Detects edges on an already-synchronized level, emits a registered
//   single-cycle pulse per edge, and counts pending events for a
//   valid/ready consumer. The counter saturates at 2^PEND_W-1.
//
// Parameters
//   EDGE_MODE  0 rising, 1 falling, 2 both (anything else fails elaboration)
//   PEND_W     pending-counter width, 1..8
//
// Ports
//   i_clk         clock, all state on rising edge
//   i_rst_n       asynchronous active-low reset
//   i_sig         input level (already in i_clk domain)
//   i_en          edge detection enable (does not gate draining)
//   i_ready       consumer accepts one event when high with o_valid
//   i_clr_ovf     synchronous clear of o_overflow
//   o_edge_pulse  one-cycle pulse per detected edge
//   o_valid       at least one event pending
//   o_pending     number of pending events
//   o_overflow    sticky drop flag
//
// Build option
//   SYNC_EDGE_EVENT_OVF_EN  defined: sticky overflow flag is built.
//                           undefined: o_overflow tied 0, i_clr_ovf ignored.
module sync_edge_event #(
  parameter int EDGE_MODE = 0,
  parameter int PEND_W    = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_sig,
  input  logic              i_en,
  input  logic              i_ready,
  input  logic              i_clr_ovf,
  output logic              o_edge_pulse,
  output logic              o_valid,
  output logic [PEND_W-1:0] o_pending,
  output logic              o_overflow
);

  generate
    if (EDGE_MODE < 0 || EDGE_MODE > 2) begin : g_bad_mode
      $error("sync_edge_event: EDGE_MODE must be 0, 1 or 2");
    end
    if (PEND_W < 1 || PEND_W > 8) begin : g_bad_width
      $error("sync_edge_event: PEND_W must be in 1..8");
    end
  endgenerate

  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  typedef enum logic {ARM, RUN} state_t;

  state_t state;
  logic   r_prev;
  logic   rise, fall, edge_sel;
  logic   inc, acc, cnt_full, drop;

  always_comb begin
    rise     = i_sig & ~r_prev;
    fall     = ~i_sig & r_prev;
    edge_sel = (EDGE_MODE == 0) ? rise :
               (EDGE_MODE == 1) ? fall : (rise | fall);
  end

  // ARM spends exactly one cycle seeding r_prev from the live level so the
  // level present at reset release is never reported as an edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= ARM;
      r_prev       <= 1'b0;
      o_edge_pulse <= 1'b0;
    end else begin
      case (state)
        ARM: begin
          r_prev       <= i_sig;
          o_edge_pulse <= 1'b0;
          state        <= RUN;
        end
        RUN: begin
          // r_prev tracks the level even while disabled, so re-enabling
          // never produces a stale edge.
          r_prev       <= i_sig;
          o_edge_pulse <= edge_sel & i_en;
        end
        default: begin
          r_prev       <= 1'b0;
          o_edge_pulse <= 1'b0;
          state        <= ARM;
        end
      endcase
    end
  end

  assign o_valid  = |o_pending;
  assign inc      = o_edge_pulse;
  assign acc      = o_valid & i_ready;
  assign cnt_full = (o_pending == PEND_MAX);
  // A simultaneous accept frees a slot, so a full counter only drops when
  // nothing is being drained that cycle.
  assign drop     = inc & ~acc & cnt_full;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_pending <= '0;
    end else if (inc && !acc && !cnt_full) begin
      o_pending <= o_pending + 1'b1;
    end else if (acc && !inc) begin
      o_pending <= o_pending - 1'b1;
    end
  end

`ifdef SYNC_EDGE_EVENT_OVF_EN
  // Set has priority over clear so a drop in the clearing cycle is kept.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)       o_overflow <= 1'b0;
    else if (drop)      o_overflow <= 1'b1;
    else if (i_clr_ovf) o_overflow <= 1'b0;
  end
`else
  logic unused_ovf;
  assign unused_ovf = i_clr_ovf ^ drop;
  assign o_overflow = 1'b0;
`endif

endmodule

// File: doc/sync_edge_event.md
SYNC_EDGE_EVENT -- requirements
Module: sync_edge_event

Interface
REQ-001 Parameter EDGE_MODE, default 0, edge type detected: 0 rising, 1 falling, 2 both; any other value SHALL fail elaboration.
REQ-002 Parameter PEND_W, default 4, pending-event counter width, legal range 1..8.
REQ-003 i_clk  input  1  sole clock; all state SHALL be on its rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 i_sig  input  1  level already synchronized into i_clk domain by the upstream two-flop crossing stage.
REQ-006 i_en  input  1  edge detection enable; when low, no new events are recorded.
REQ-007 o_edge_pulse  output  1  single-cycle pulse per detected edge.
REQ-008 o_valid  output  1  at least one event pending.
REQ-009 i_ready  input  1  consumer accepts one event when high with o_valid at a clock edge.
REQ-010 o_pending  output  PEND_W  number of pending events.
REQ-011 o_overflow  output  1  sticky: an event was dropped at counter saturation.
REQ-012 i_clr_ovf  input  1  synchronous clear of o_overflow.

Function
REQ-013 FSM with states ARM and RUN; reset enters ARM.
REQ-014 ARM: r_prev SHALL load i_sig, no edge detected; next state RUN unconditionally (exactly one cycle).
REQ-015 RUN: rise = i_sig & ~r_prev, fall = ~i_sig & r_prev; r_prev SHALL load i_sig every cycle, independent of i_en.
REQ-016 Detected edge = selected per EDGE_MODE, gated by i_en sampled at the same edge.
REQ-017 o_edge_pulse SHALL be registered: high exactly the one cycle following the clock edge that samples the transition on i_sig.
REQ-018 Counter increments on o_edge_pulse; decrements on o_valid & i_ready; both in same cycle -> unchanged.
REQ-019 o_valid SHALL equal (o_pending != 0) combinationally from the counter register; first o_valid appears two cycles after the sampling edge.
REQ-020 Increment at count 2^PEND_W-1 without simultaneous accept SHALL leave count saturated and record a drop.
REQ-021 i_ready while o_valid low SHALL have no effect; counter never underflows.
REQ-022 Back-to-back edges (EDGE_MODE 2, i_sig toggling every cycle) SHALL each produce a pulse and a count.
REQ-023 i_en low SHALL not block draining of pending events.

Reset
REQ-024 Asserting i_rst_n low at any time SHALL immediately force: state ARM, r_prev 0, o_edge_pulse 0, o_pending 0, o_valid 0, o_overflow 0.
REQ-025 Reset mid-operation SHALL discard all pending events; no edge SHALL be reported for the i_sig level present at reset release.

Configuration
REQ-026 Macro SYNC_EDGE_EVENT_OVF_EN defined: o_overflow sets on any drop per REQ-020, holds until i_clr_ovf; simultaneous drop and i_clr_ovf -> o_overflow remains 1 (set wins).
REQ-027 Macro undefined: no overflow logic built, o_overflow tied 0, i_clr_ovf ignored; saturation behaviour of REQ-020 unchanged.

Verification
REQ-028 i_sig held 1 through reset release, EDGE_MODE 0 -> no o_edge_pulse, o_pending stays 0.
REQ-029 EDGE_MODE 0, i_en 1, i_sig 0->1 sampled at edge k -> o_edge_pulse high cycle k+1, o_valid and o_pending=1 from cycle k+2; i_ready 1 one cycle -> o_pending 0.
REQ-030 EDGE_MODE 2, PEND_W 2, i_ready 0, i_sig toggling 5 times -> o_pending saturates at 3, o_overflow 1 (macro defined) / 0 (undefined).
REQ-031 o_pending=2, new edge pulse coincident with accept -> o_pending stays 2; i_ready held with o_pending 0 -> stays 0.
REQ-032 i_en 0 during rising edge -> no pulse, no count; pending events still drain with i_ready 1.
REQ-033 o_pending=3, i_rst_n pulsed low mid-cycle -> all outputs 0 asynchronously, ARM one cycle after release, subsequent edges counted normally.
